// File: rtl/uart_tx_packetizer_pkg.sv
// uart_tx_packetizer_pkg
//   Shared definitions for the UART packetizer: FSM state encoding, the
//   default sync byte, counter/checksum widths and a length clamp helper.
package uart_tx_packetizer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CSUM_W            = 8;
  localparam int         WORD_CNT_W        = 8;
  localparam int         BYTE_IDX_W        = 2;

  // IDLE is all-zero so the state debug output reads 0 after reset.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_TYPE    = 3'd3,
    ST_LEN     = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CSUM    = 3'd6,
    ST_RELEASE = 3'd7
  } state_e;

  // Lengths above the configured maximum are clamped, not rejected.
  function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                           input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/uart_tx_packetizer_byte_serializer.sv
// byte_serializer
//   Selects one byte of a 32-bit word, index 0 = least-significant byte.
//   Ports:
//     word_in  [31:0] word being serialized
//     idx      [1:0]  byte index within the word
//     byte_out [7:0]  selected byte
module byte_serializer (
  input  logic [31:0] word_in,
  input  logic [1:0]  idx,
  output logic [7:0]  byte_out
);

  always_comb begin
    byte_out = word_in[7:0];
    case (idx)
      2'd0: byte_out = word_in[7:0];
      2'd1: byte_out = word_in[15:8];
      2'd2: byte_out = word_in[23:16];
      2'd3: byte_out = word_in[31:24];
      default: byte_out = word_in[7:0];
    endcase
  end

endmodule

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer
//   Frames a packet onto a shared UART write port:
//     SYNC_BYTE, type, length, payload (LSB first, 4 bytes/word), checksum.
//   The checksum is the 8-bit wrap-around sum of type, length and payload.
//   The UART port is owned through a lock_req/lock_grant pair.
//
//   Handshakes:
//     word_in  : transfer on a clock edge where word_valid && word_ready.
//     data_out : transfer on a clock edge where data_out_valid is high;
//                data_out_valid already includes lock_grant && write_ready,
//                so every cycle it is high is exactly one accepted byte.
//
//   Ports:
//     clock, reset            system clock, synchronous active-high reset
//     pkt_start/type/len      packet request (sampled only in IDLE)
//     word_in/valid/ready     payload word stream
//     busy, done              status (done pulses when the lock is released)
//     lock_req, lock_grant    UART port ownership
//     write_ready             UART FIFO not full
//     data_out, data_out_valid byte stream to the UART
//     state_dbg               current FSM state
module uart_tx_packetizer
  import uart_tx_packetizer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_WORDS = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pkt_start,
  input  logic [7:0]  pkt_type,
  input  logic [7:0]  pkt_len,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        lock_req,
  input  logic        lock_grant,
  input  logic        write_ready,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0] MAX_LEN = (MAX_WORDS > 255) ? 8'd255 : MAX_WORDS[7:0];

  state_e                  state_q, state_d;
  logic [7:0]              type_q, type_d;
  logic [7:0]              len_q, len_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;   // words loaded so far
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [CSUM_W-1:0]       csum_q, csum_d;
  logic [31:0]             hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;

  logic [7:0]              ser_byte;
  logic [7:0]              cur_byte;
  logic                    have_byte;
  logic                    accept;
  logic                    words_left;

  byte_serializer u_ser (
    .word_in  (hold_q),
    .idx      (byte_idx_q),
    .byte_out (ser_byte)
  );

  // Byte currently offered to the UART. It only depends on registers that
  // change on acceptance, so it is stable while a byte is stalled.
  always_comb begin
    cur_byte  = 8'h00;
    have_byte = 1'b0;
    case (state_q)
      ST_SYNC:    begin cur_byte = SYNC_BYTE; have_byte = 1'b1;        end
      ST_TYPE:    begin cur_byte = type_q;    have_byte = 1'b1;        end
      ST_LEN:     begin cur_byte = len_q;     have_byte = 1'b1;        end
      ST_PAYLOAD: begin cur_byte = ser_byte;  have_byte = hold_full_q; end
      ST_CSUM:    begin cur_byte = csum_q;    have_byte = 1'b1;        end
      default:    begin cur_byte = 8'h00;     have_byte = 1'b0;        end
    endcase
  end

  assign accept         = have_byte & lock_grant & write_ready;
  assign data_out_valid = accept;
  assign data_out       = cur_byte;
  assign words_left     = (word_cnt_q != len_q);
  assign word_ready     = (state_q == ST_PAYLOAD) & ~hold_full_q & words_left;
  assign busy           = (state_q != ST_IDLE);
  assign lock_req       = (state_q != ST_IDLE) & (state_q != ST_RELEASE);
  assign done           = (state_q == ST_RELEASE) & ~lock_grant;
  assign state_dbg      = state_q;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (pkt_start) begin
          state_d     = ST_REQ;
          type_d      = pkt_type;
          len_d       = clamp_len(pkt_len, MAX_LEN);
          word_cnt_d  = '0;
          byte_idx_d  = '0;
          csum_d      = '0;
          hold_full_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (lock_grant) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (accept) state_d = ST_TYPE;
      end
      ST_TYPE: begin
        if (accept) begin
          csum_d  = csum_q + type_q;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          csum_d  = csum_q + len_q;
          state_d = (len_q != 8'd0) ? ST_PAYLOAD : ST_CSUM;
        end
      end
      ST_PAYLOAD: begin
        // Loading and draining never coincide: word_ready needs an empty
        // register and a byte is only offered from a full one.
        if (word_ready && word_valid) begin
          hold_d      = word_in;
          hold_full_d = 1'b1;
          word_cnt_d  = word_cnt_q + 1'b1;
        end
        if (accept) begin
          csum_d     = csum_q + ser_byte;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            hold_full_d = 1'b0;
            if (!words_left) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!lock_grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      type_q      <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer
//   Bench for uart_tx_packetizer. A packet model turns (type, len, words)
//   into the expected byte list; a negedge monitor pops it on every
//   accepted byte. Grant, write_ready and word feeding run as independent
//   processes steered by knobs from the main sequence.
module tb_uart_tx_packetizer;

  localparam int MAX_W = 8;

  logic        clock;
  logic        reset;
  logic        pkt_start;
  logic [7:0]  pkt_type;
  logic [7:0]  pkt_len;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        lock_req;
  logic        lock_grant;
  logic        write_ready;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic [2:0]  state_dbg;

  uart_tx_packetizer #(.SYNC_BYTE(8'hA5), .MAX_WORDS(MAX_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .pkt_start      (pkt_start),
    .pkt_type       (pkt_type),
    .pkt_len        (pkt_len),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .busy           (busy),
    .done           (done),
    .lock_req       (lock_req),
    .lock_grant     (lock_grant),
    .write_ready    (write_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] word_q[$];
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          exp_total = 0;

  // knobs
  int grant_delay   = 0;
  bit grant_drop_en = 1'b0;
  bit wr_rand       = 1'b0;
  bit wr_force_low  = 1'b0;
  int gap_min       = 0;
  int gap_max       = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (data_out_valid) begin
          check_eq("valid_gate", {30'd0, lock_grant, write_ready}, 32'd3);
          if (exp_q.size() == 0)
            check_eq("unexpected_byte", 32'(exp_q.size()), 32'd1);
          else
            check_eq("byte", 32'(data_out), 32'(exp_q.pop_front()));
          acc_cnt++;
        end
        if (done) done_cnt++;
        if (word_ready) wr_cnt++;
      end
    end
  end

  // ---------------- lock grant driver ----------------
  initial begin
    int gcnt;
    gcnt = 0;
    lock_grant = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (reset || !lock_req) begin
        lock_grant = 1'b0;
        gcnt = 0;
      end else if (!lock_grant) begin
        if (gcnt >= grant_delay) lock_grant = 1'b1;
        else gcnt++;
      end else if (grant_drop_en && $urandom_range(7, 0) == 0) begin
        lock_grant = 1'b0;
        gcnt = 0;
      end
    end
  end

  // ---------------- write_ready driver ----------------
  initial begin
    write_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (wr_force_low) write_ready = 1'b0;
      else if (wr_rand) write_ready = ($urandom_range(3, 0) != 0);
      else write_ready = 1'b1;
    end
  end

  // ---------------- word feeder ----------------
  initial begin
    bit took;
    int gap;
    gap = 0;
    word_valid = 1'b0;
    word_in = '0;
    forever begin
      @(negedge clock);
      took = !reset && word_valid && word_ready;
      @(posedge clock);
      #1;
      if (reset) begin
        word_q.delete();
        word_valid = 1'b0;
        gap = 0;
      end else if (took) begin
        void'(word_q.pop_front());
        word_valid = 1'b0;
        gap = $urandom_range(gap_max, gap_min);
      end else if (!word_valid) begin
        if (gap > 0) gap--;
        if (gap == 0 && word_q.size() > 0) begin
          word_valid = 1'b1;
          word_in = word_q[0];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Builds the expected byte list from the packet rules and issues the start.
  task automatic start_pkt(input logic [7:0] typ, input logic [7:0] len,
                           input bit fixed, input logic [31:0] fw);
    int          lc;
    logic [7:0]  cs;
    logic [7:0]  by;
    logic [31:0] w;
    lc = (int'(len) > MAX_W) ? MAX_W : int'(len);
    cs = typ + 8'(lc);
    exp_q.push_back(8'hA5);
    exp_q.push_back(typ);
    exp_q.push_back(8'(lc));
    for (int i = 0; i < lc; i++) begin
      w = fixed ? fw : $urandom;
      word_q.push_back(w);
      for (int b = 0; b < 4; b++) begin
        by = w[8*b +: 8];
        exp_q.push_back(by);
        cs = cs + by;
      end
    end
    exp_q.push_back(cs);
    exp_total = 4 + 4 * lc;
    acc_cnt = 0;
    done_cnt = 0;
    wr_cnt = 0;
    pkt_start = 1'b1;
    pkt_type = typ;
    pkt_len = len;
    tick();
    pkt_start = 1'b0;
    pkt_type = 8'($urandom);
    pkt_len = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (3) tick();
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_bytes"}, 32'(acc_cnt), 32'(exp_total));
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check_eq({tag, "_reach"}, 32'(acc_cnt >= target), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    pkt_start = 1'b0;
    pkt_type = '0;
    pkt_len = '0;
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_lock_req", 32'(lock_req), 32'd0);
    check_eq("rst_valid", 32'(data_out_valid), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_word_ready", 32'(word_ready), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick();

    // A5 03 01 44 33 22 11 AE
    start_pkt(8'h03, 8'd1, 1'b1, 32'h11223344);
    wait_done("one_word");

    // A5 7F 00 7F, no payload request
    start_pkt(8'h7F, 8'd0, 1'b0, 32'h0);
    wait_done("zero_len");
    check_eq("zero_len_word_ready", 32'(wr_cnt), 32'd0);

    // write_ready low for 5 cycles while payload byte 2 is pending
    start_pkt(8'h5C, 8'd2, 1'b0, 32'h0);
    wait_bytes("stall", 5);
    wr_force_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("stall_valid", 32'(data_out_valid), 32'd0);
      check_eq("stall_hold", 32'(data_out), 32'(exp_q[0]));
    end
    wr_force_low = 1'b0;
    wait_done("stall");

    // grant arrives 10 cycles after the request
    grant_delay = 10;
    start_pkt(8'h3C, 8'd1, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (lock_grant) break;
      check_eq("late_grant_valid", 32'(data_out_valid), 32'd0);
    end
    wait_done("late_grant");
    grant_delay = 0;

    // reset mid-payload, then a fresh packet
    start_pkt(8'h21, 8'd3, 1'b0, 32'h0);
    wait_bytes("midrst", 6);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("midrst_lock_req", 32'(lock_req), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_valid", 32'(data_out_valid), 32'd0);
    check_eq("midrst_word_ready", 32'(word_ready), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    start_pkt(8'h42, 8'd2, 1'b0, 32'h0);
    wait_done("after_rst");

    // start pulsed while busy, words gapped by 3 cycles
    gap_min = 3;
    gap_max = 3;
    start_pkt(8'h99, 8'd3, 1'b0, 32'h0);
    wait_bytes("restart", 2);
    #1;
    pkt_start = 1'b1;
    pkt_type = 8'hEE;
    pkt_len = 8'd1;
    tick();
    pkt_start = 1'b0;
    wait_done("restart");
    gap_min = 0;
    gap_max = 0;

    // length above MAX_WORDS is clamped
    start_pkt(8'h10, 8'd200, 1'b0, 32'h0);
    wait_done("clamp");

    // randomized traffic with grant drops, FIFO backpressure and word gaps
    grant_drop_en = 1'b1;
    wr_rand = 1'b1;
    gap_max = 2;
    for (int p = 0; p < 20; p++) begin
      grant_delay = $urandom_range(3, 0);
      start_pkt(8'($urandom), 8'($urandom_range(10, 0)), 1'b0, 32'h0);
      wait_done("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
